// File: rtl/move_out_fifo_if.sv
// Handshake bundle between the move generator / CPU side and the move-out FIFO.
// The master modport drives the strobes; the slave modport is the FIFO itself.
interface move_out_fifo_if #(
  parameter int AW = 8
);
  logic          fpga_cpu_fifo_wr;
  logic [31:0]   fpga_cpu_fifo_wdata;
  logic          fpga_cpu_interrupt;
  logic          cpu_rd;
  logic          cpu_ack;
  logic [15:0]   cpu_rdata;
  logic          cpu_rdata_dav;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic [AW:0]   job_count;
  logic          overflow;
  logic          cpu_irq;

  modport master (
    output fpga_cpu_fifo_wr, fpga_cpu_fifo_wdata, fpga_cpu_interrupt, cpu_rd, cpu_ack,
    input  cpu_rdata, cpu_rdata_dav, empty, full, count, job_count, overflow, cpu_irq
  );

  modport slave (
    input  fpga_cpu_fifo_wr, fpga_cpu_fifo_wdata, fpga_cpu_interrupt, cpu_rd, cpu_ack,
    output cpu_rdata, cpu_rdata_dav, empty, full, count, job_count, overflow, cpu_irq
  );
endinterface

// File: rtl/move_out_fifo.sv
// Circular buffer of 16-bit moves from the move generator to the CPU, with a
// job-done interrupt handshake and a sticky overflow flag.
module move_out_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  move_out_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, IRQ, DRAIN} state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t        state_reg, state_next;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next, job_count_reg;
  logic [15:0]   rdata_reg;
  logic          dav_reg, overflow_reg, irq;
  logic          empty, full, rd_acc, wr_acc, job_latch;
  logic          unused_wdata_hi;

  assign unused_wdata_hi = ^bus.fpga_cpu_fifo_wdata[31:16];

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == FULL_COUNT);
  assign rd_acc = bus.cpu_rd && !empty;
  // A read in the same cycle frees the slot the write needs, even when full.
  assign wr_acc = bus.fpga_cpu_fifo_wr && (!full || rd_acc);

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= bus.fpga_cpu_fifo_wdata[15:0];
  end

  assign job_latch = ((state_reg == IDLE) || (state_reg == FILL)) && (state_next == IRQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      job_count_reg <= '0;
      rdata_reg     <= '0;
      dav_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      dav_reg   <= rd_acc;
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_acc) begin
        rdata_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // A dropped write beats a simultaneous acknowledge.
      if (bus.fpga_cpu_fifo_wr && !wr_acc) overflow_reg <= 1'b1;
      else if (bus.cpu_ack)                overflow_reg <= 1'b0;
      if (job_latch) job_count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (bus.fpga_cpu_interrupt) state_next = IRQ;
             else if (wr_acc)            state_next = FILL;
      FILL:  if (bus.fpga_cpu_interrupt) state_next = IRQ;
      IRQ:   if (bus.cpu_ack)            state_next = IDLE;
             else if (rd_acc)            state_next = DRAIN;
      DRAIN: if (bus.cpu_ack)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_comb begin
    irq = 1'b0;
    if ((state_reg == IRQ) || (state_reg == DRAIN)) irq = 1'b1;
  end

  assign bus.cpu_rdata     = rdata_reg;
  assign bus.cpu_rdata_dav = dav_reg;
  assign bus.empty         = empty;
  assign bus.full          = full;
  assign bus.count         = count_reg;
  assign bus.job_count     = job_count_reg;
  assign bus.overflow      = overflow_reg;
  assign bus.cpu_irq       = irq;
endmodule

// File: tb/tb_move_out_fifo.sv
// Directed bench for move_out_fifo: stimulus pushes expected read data into a
// scoreboard queue, an independent monitor pops it on every dav pulse.
module tb_move_out_fifo;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  move_out_fifo_if #(.AW(AW)) bus ();

  move_out_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] model[$];
  logic [15:0] sb[$];
  logic [15:0] exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the queue model predicts which read data must appear.
  task automatic cycle(input logic wr, input logic [31:0] wd, input logic rd,
                       input logic intr, input logic ack);
    bit rd_ok, wr_ok;
    bus.fpga_cpu_fifo_wr    = wr;
    bus.fpga_cpu_fifo_wdata = wd;
    bus.cpu_rd              = rd;
    bus.fpga_cpu_interrupt  = intr;
    bus.cpu_ack             = ack;
    rd_ok = rd && (model.size() != 0);
    wr_ok = wr && ((model.size() < DEPTH) || rd_ok);
    if (rd_ok) sb.push_back(model.pop_front());
    if (wr_ok) model.push_back(wd[15:0]);
    @(posedge clk);
    #1;
    bus.fpga_cpu_fifo_wr    = 1'b0;
    bus.fpga_cpu_fifo_wdata = '0;
    bus.cpu_rd              = 1'b0;
    bus.fpga_cpu_interrupt  = 1'b0;
    bus.cpu_ack             = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"},     32'(bus.empty), 32'd1);
    check({tag, "_full"},      32'(bus.full), 32'd0);
    check({tag, "_count"},     32'(bus.count), 32'd0);
    check({tag, "_job_count"}, 32'(bus.job_count), 32'd0);
    check({tag, "_overflow"},  32'(bus.overflow), 32'd0);
    check({tag, "_irq"},       32'(bus.cpu_irq), 32'd0);
    check({tag, "_rdata"},     32'(bus.cpu_rdata), 32'd0);
    check({tag, "_dav"},       32'(bus.cpu_rdata_dav), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus.cpu_rdata_dav !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL dav_unexpected actual=%0h required=no_pulse", bus.cpu_rdata);
      end else begin
        exp_data = sb.pop_front();
        if (bus.cpu_rdata !== exp_data) begin
          errors++;
          $display("FAIL read_data actual=%0h required=%0h", bus.cpu_rdata, exp_data);
        end else begin
          $display("read %04h ok", bus.cpu_rdata);
        end
      end
    end
  end

  initial begin
    bus.fpga_cpu_fifo_wr    = 1'b0;
    bus.fpga_cpu_fifo_wdata = '0;
    bus.cpu_rd              = 1'b0;
    bus.fpga_cpu_interrupt  = 1'b0;
    bus.cpu_ack             = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0);

    // Basic job: two writes, done pulse, two reads.
    cycle(1, 32'h0000_1234, 0, 0, 0);
    cycle(1, 32'h0000_5678, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    check("job_irq", 32'(bus.cpu_irq), 32'd1);
    check("job_count_2", 32'(bus.job_count), 32'd2);
    check("job_fifo_count", 32'(bus.count), 32'd2);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_irq", 32'(bus.cpu_irq), 32'd1);
    cycle(0, 0, 0, 0, 1);
    check("ack_irq_low", 32'(bus.cpu_irq), 32'd0);

    // Write coinciding with done pulse is counted; later pulses don't re-latch.
    cycle(1, 32'h0000_AAAA, 0, 1, 0);
    check("latch_same_cycle_write", 32'(bus.job_count), 32'd1);
    check("latch_irq", 32'(bus.cpu_irq), 32'd1);
    cycle(1, 32'h0000_BBBB, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    check("no_relatch", 32'(bus.job_count), 32'd1);
    check("write_in_irq_count", 32'(bus.count), 32'd2);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1);
    check("ack_beats_interrupt", 32'(bus.cpu_irq), 32'd0);
    cycle(0, 0, 1, 0, 0);
    check("second_job_empty", 32'(bus.count), 32'd0);

    // Fill to the brim, upper data bits are junk and must be ignored.
    for (int i = 0; i < DEPTH; i++) cycle(1, {16'hDEAD, 16'(16'h1000 + i)}, 0, 0, 0);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd256);
    check("fill_no_overflow", 32'(bus.overflow), 32'd0);
    cycle(1, 32'h0000_FFFF, 0, 0, 0);
    check("overflow_set", 32'(bus.overflow), 32'd1);
    check("overflow_count", 32'(bus.count), 32'd256);
    cycle(0, 0, 0, 0, 1);
    check("overflow_cleared", 32'(bus.overflow), 32'd0);
    check("ack_in_fill_irq", 32'(bus.cpu_irq), 32'd0);
    cycle(1, 32'h0000_FFFF, 0, 0, 1);
    check("overflow_beats_ack", 32'(bus.overflow), 32'd1);
    cycle(0, 0, 0, 0, 1);
    check("overflow_cleared_again", 32'(bus.overflow), 32'd0);

    // Simultaneous write and read at full.
    cycle(1, 32'h0000_7777, 1, 0, 0);
    check("full_rw_count", 32'(bus.count), 32'd256);
    check("full_rw_full", 32'(bus.full), 32'd1);
    check("full_rw_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0, 0);
    check("full_drain_count", 32'(bus.count), 32'd0);
    check("full_drain_empty", 32'(bus.empty), 32'd1);

    // Read and write together on empty: no fall-through.
    cycle(1, 32'h0000_4242, 1, 0, 0);
    check("empty_rw_dav", 32'(bus.cpu_rdata_dav), 32'd0);
    check("empty_rw_count", 32'(bus.count), 32'd1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("empty_read_no_dav", 32'(bus.cpu_rdata_dav), 32'd0);
    check("empty_read_hold", 32'(bus.cpu_rdata), 32'h4242);

    // Streaming with wrap-around.
    for (int i = 0; i < 300; i++) begin
      cycle(1, {16'h0, 16'(16'h2000 + i)}, (i >= 4), 0, 0);
      check("stream_bound", 32'(bus.count <= 10), 32'd1);
    end
    check("stream_count", 32'(bus.count), 32'd4);
    repeat (4) cycle(0, 0, 1, 0, 0);
    check("stream_empty", 32'(bus.empty), 32'd1);

    // Reset in the middle of a drain.
    for (int i = 0; i < 6; i++) cycle(1, {16'h0, 16'(16'h3000 + i)}, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("pre_reset_count", 32'(bus.count), 32'd5);
    check("pre_reset_irq", 32'(bus.cpu_irq), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_values("midjob");
    model.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(0, 0, 1, 0, 0);
    check("post_reset_no_dav", 32'(bus.cpu_rdata_dav), 32'd0);
    check("post_reset_empty", 32'(bus.empty), 32'd1);
    check("post_reset_rdata", 32'(bus.cpu_rdata), 32'd0);

    repeat (2) cycle(0, 0, 0, 0, 0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
